// File: rtl/stepper_move_ctrl.sv
// Stepper motor move controller: runs a counted move through an 8-entry phase table
// in wave, full or half-step mode, one step every period+1 clocks.
module stepper_move_ctrl #(
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned CNT_W     = 12,
    parameter bit          IDLE_HOLD = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] steps,
    input  logic [DIV_W-1:0] period,
    input  logic             abort,
    output logic [3:0]       coil_signals,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] steps_left
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e           state_q;
    logic [2:0]       idx_q;
    logic [2:0]       idx_step;
    logic [2:0]       delta;
    logic [DIV_W-1:0] tick_q;
    logic [DIV_W-1:0] period_q;
    logic             dir_q;
    logic [1:0]       mode_q;
    logic [3:0]       idle_coils;

    function automatic logic [3:0] phase(input logic [2:0] i);
        case (i)
            3'd0:    phase = 4'b1000;
            3'd1:    phase = 4'b1100;
            3'd2:    phase = 4'b0100;
            3'd3:    phase = 4'b0110;
            3'd4:    phase = 4'b0010;
            3'd5:    phase = 4'b0011;
            3'd6:    phase = 4'b0001;
            default: phase = 4'b1001;
        endcase
    endfunction

    // Full mode settles on odd indices, wave on even; half (and 11) always moves by one.
    always_comb begin
        delta = 3'd1;
        if (!mode_q[1]) begin
            if (mode_q[0]) delta = idx_q[0] ? 3'd2 : 3'd1;
            else           delta = idx_q[0] ? 3'd1 : 3'd2;
        end
        idx_step   = dir_q ? (idx_q - delta) : (idx_q + delta);
        idle_coils = IDLE_HOLD ? phase(idx_q) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            tick_q       <= '0;
            period_q     <= '0;
            dir_q        <= 1'b0;
            mode_q       <= '0;
            steps_left   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            coil_signals <= 4'b0000;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    coil_signals <= idle_coils;
                    if (start) begin
                        if (steps != '0) begin
                            state_q      <= StRun;
                            busy         <= 1'b1;
                            dir_q        <= dir;
                            mode_q       <= mode;
                            period_q     <= period;
                            steps_left   <= steps;
                            tick_q       <= '0;
                            coil_signals <= phase(idx_q);
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (abort) begin
                        // Abort wins over any step due this cycle; remaining count is kept.
                        state_q      <= StIdle;
                        busy         <= 1'b0;
                        tick_q       <= '0;
                        coil_signals <= idle_coils;
                    end else if (tick_q == period_q) begin
                        tick_q     <= '0;
                        idx_q      <= idx_step;
                        steps_left <= steps_left - CNT_W'(1);
                        if (steps_left == CNT_W'(1)) begin
                            state_q      <= StIdle;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            coil_signals <= IDLE_HOLD ? phase(idx_step) : 4'b0000;
                        end else begin
                            coil_signals <= phase(idx_step);
                        end
                    end else begin
                        tick_q <= tick_q + DIV_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Scoreboard bench for stepper_move_ctrl: two instances (coils held / released in idle)
// share stimulus; expected step records are queued at start and checked by cycle number.
module tb_stepper_move_ctrl;

    localparam int DIV_W = 16;
    localparam int CNT_W = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             dir;
    logic [1:0]       mode;
    logic [CNT_W-1:0] steps;
    logic [DIV_W-1:0] period;
    logic             abort;
    logic [3:0]       coil_h, coil_z;
    logic             busy_h, busy_z, done_h, done_z;
    logic [CNT_W-1:0] left_h, left_z;

    always #5 clk = ~clk;

    stepper_move_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W), .IDLE_HOLD(1'b1)) u_dut_hold (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .mode(mode), .steps(steps),
        .period(period), .abort(abort), .coil_signals(coil_h), .busy(busy_h), .done(done_h),
        .steps_left(left_h)
    );

    stepper_move_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W), .IDLE_HOLD(1'b0)) u_dut_free (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .mode(mode), .steps(steps),
        .period(period), .abort(abort), .coil_signals(coil_z), .busy(busy_z), .done(done_z),
        .steps_left(left_z)
    );

    typedef struct {
        int               cyc;
        logic [3:0]       coil;
        logic [3:0]       coil0;
        logic             chk0;
        logic [CNT_W-1:0] left;
        logic             busy;
        logic             done;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         cyc      = 0;
    int         n_vec    = 0;
    int         n_err    = 0;
    int         done_cnt = 0;
    int         m_idx    = 0;
    int         m_left   = 0;
    logic [3:0] tbl[8]   = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                             4'b0010, 4'b0011, 4'b0001, 4'b1001};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (done_h) done_cnt++;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc == cyc) begin
            mon_e = sb.pop_front();
            check($sformatf("coil@%0d", mon_e.cyc), 32'(coil_h), 32'(mon_e.coil));
            check($sformatf("left@%0d", mon_e.cyc), 32'(left_h), 32'(mon_e.left));
            check($sformatf("busy@%0d", mon_e.cyc), 32'(busy_h), 32'(mon_e.busy));
            check($sformatf("done@%0d", mon_e.cyc), 32'(done_h), 32'(mon_e.done));
            check($sformatf("busy_free@%0d", mon_e.cyc), 32'(busy_z), 32'(mon_e.busy));
            if (mon_e.chk0)
                check($sformatf("coil_free@%0d", mon_e.cyc), 32'(coil_z), 32'(mon_e.coil0));
        end
    end

    // Phase walk: one index at a time until the mode's parity target is met.
    function automatic int next_idx(input int i, input logic [1:0] md, input logic d);
        int j;
        j = d ? (i + 7) % 8 : (i + 1) % 8;
        if ((md == 2'b01 && j % 2 == 0) || (md == 2'b00 && j % 2 == 1))
            j = d ? (j + 7) % 8 : (j + 1) % 8;
        return j;
    endfunction

    task automatic push_exp(input int c, input logic [3:0] cl, input logic [3:0] cl0,
                            input logic k0, input int lf, input logic b, input logic dn);
        exp_t x;
        x.cyc   = c;
        x.coil  = cl;
        x.coil0 = cl0;
        x.chk0  = k0;
        x.left  = CNT_W'(lf);
        x.busy  = b;
        x.done  = dn;
        sb.push_back(x);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_coil", 32'(coil_h), 32'h0);
        check("rst_coil_free", 32'(coil_z), 32'h0);
        check("rst_busy", 32'(busy_h), 32'h0);
        check("rst_done", 32'(done_h), 32'h0);
        check("rst_left", 32'(left_h), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_coil", 32'(coil_h), 32'h8);
        check("idle_coil_free", 32'(coil_z), 32'h0);
        check("idle_busy", 32'(busy_h), 32'h0);
        m_idx  = 0;
        m_left = 0;
    endtask

    // ab_edge: clock edge (counted from acceptance) at which abort is sampled; 0 = none.
    task automatic run_move(input logic [1:0] md, input logic d, input int n, input int p,
                            input int ab_edge);
        int acc, idx, e, taken, d0, exp_done;
        logic last;
        @(negedge clk);
        mode   = md;
        dir    = d;
        steps  = CNT_W'(n);
        period = DIV_W'(p);
        start  = 1'b1;
        acc    = cyc + 1;
        idx    = m_idx;
        d0     = done_cnt;
        taken  = 0;
        if (n == 0) begin
            push_exp(acc, tbl[idx], 4'b0000, 1'b1, m_left, 1'b0, 1'b1);
            push_exp(acc + 1, tbl[idx], 4'b0000, 1'b1, m_left, 1'b0, 1'b0);
            exp_done = 1;
        end else begin
            push_exp(acc, tbl[idx], tbl[idx], 1'b1, n, 1'b1, 1'b0);
            for (int k = 1; k <= n; k++) begin
                e = k * (p + 1);
                if (ab_edge != 0 && e >= ab_edge) break;
                idx   = next_idx(idx, md, d);
                taken = k;
                last  = (k == n);
                push_exp(acc + e, tbl[idx], tbl[idx], !last, n - k, !last, last);
                if (last) push_exp(acc + e + 1, tbl[idx], 4'b0000, 1'b1, 0, 1'b0, 1'b0);
            end
            if (taken < n)
                push_exp(acc + ab_edge, tbl[idx], 4'b0000, 1'b1, n - taken, 1'b0, 1'b0);
            m_left   = (taken < n) ? n - taken : 0;
            exp_done = (taken < n) ? 0 : 1;
        end
        m_idx = idx;
        @(negedge clk);
        if (n != 0) begin
            // start held one more edge while running, with all move inputs scrambled.
            mode   = 2'($urandom);
            dir    = 1'($urandom);
            steps  = CNT_W'($urandom_range(1, 50));
            period = DIV_W'($urandom_range(0, 7));
        end else begin
            start = 1'b0;
        end
        @(negedge clk);
        start = 1'b0;
        if (ab_edge != 0) begin
            while (cyc < acc + ab_edge - 1) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
        for (int t = 0; t < 2000 && sb.size() > 0; t++) @(negedge clk);
        if (sb.size() != 0) begin
            check("sb_drain", 32'(sb.size()), 32'h0);
            sb.delete();
        end
        @(negedge clk);
        check("done_count", 32'(done_cnt - d0), 32'(exp_done));
    endtask

    task automatic mid_reset();
        int d0;
        @(negedge clk);
        mode   = 2'b10;
        dir    = 1'b0;
        steps  = CNT_W'(20);
        period = DIV_W'(1);
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy", 32'(busy_h), 32'h1);
        d0 = done_cnt;
        do_reset();
        check("mid_done_count", 32'(done_cnt - d0), 32'h0);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        dir    = 1'b0;
        mode   = 2'b00;
        steps  = '0;
        period = '0;
        do_reset();
        run_move(2'b10, 1'b0, 3, 2, 0);    // half forward, period 2
        do_reset();
        run_move(2'b01, 1'b1, 2, 0, 0);    // full reverse from index 0
        run_move(2'b00, 1'b0, 4, 1, 0);    // wave forward from odd index
        run_move(2'b10, 1'b0, 10, 4, 21);  // abort just after the 4th step
        run_move(2'b11, 1'b1, 3, 0, 0);    // mode 11 behaves as half
        run_move(2'b00, 1'b0, 0, 3, 0);    // zero-step start
        run_move(2'b01, 1'b0, 3, 1, 6);    // abort coincident with final step
        run_move(2'b10, 1'b1, 0, 0, 0);    // zero-step with retained remaining count
        mid_reset();
        run_move(2'b01, 1'b0, 2, 0, 0);    // full forward after reset
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stepper_move_ctrl.md
STEPPER_MOVE_CTRL -- requirements
Module: stepper_move_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 16: width of the step-period input.
REQ-002 SHALL have parameter CNT_W, default 12: width of the step-count input and counter.
REQ-003 SHALL have parameter IDLE_HOLD, default 1: 1 = coils stay energised when idle; 0 = coils released (4'b0000) when idle.
REQ-004 SHALL have port clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: move request, sampled only in IDLE.
REQ-007 SHALL have port dir, input, 1 bit: 0 = forward (index increments), 1 = reverse (index decrements).
REQ-008 SHALL have port mode, input, 2 bits: 00 = wave, 01 = full, 10 = half, 11 = treated as half.
REQ-009 SHALL have port steps, input, CNT_W bits: number of steps in the move.
REQ-010 SHALL have port period, input, DIV_W bits: step interval minus 1, in clk cycles.
REQ-011 SHALL have port abort, input, 1 bit: terminates the active move.
REQ-012 SHALL have port coil_signals, output, 4 bits: registered coil drive.
REQ-013 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when a move completes.
REQ-015 SHALL have port steps_left, output, CNT_W bits: remaining steps in the current move.

Function
REQ-016 SHALL use an 8-entry phase table indexed 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001; the 3-bit index wraps modulo 8.
REQ-017 SHALL implement two states: IDLE and RUN.
REQ-018 SHALL accept start in IDLE with steps != 0 by latching dir, mode, steps and period, loading steps_left = steps, clearing the tick counter, and entering RUN with busy = 1 on the next cycle.
REQ-019 SHALL respond to start in IDLE with steps == 0 by pulsing done on the next cycle, staying in IDLE, and leaving the index unchanged.
REQ-020 SHALL ignore start and all input changes other than abort while in RUN; latched values govern the move.
REQ-021 SHALL use a tick counter that counts 0..period in RUN and issues a step when it equals the latched period, then returns it to 0; the first step occurs period+1 cycles after entering RUN, and period = 0 gives one step per clock.
REQ-022 SHALL, on a step in half mode, move the index by ±1.
REQ-023 SHALL, on a step in full mode, move the index by ±2 if the index is odd, else by ±1 so it lands on an odd index.
REQ-024 SHALL, on a step in wave mode, move the index by ±2 if the index is even, else by ±1 so it lands on an even index.
REQ-025 SHALL update coil_signals to the new table entry in the same cycle the index updates, and SHALL decrement steps_left on every step.
REQ-026 SHALL, on the step that brings steps_left to 0, return to IDLE, deassert busy, and pulse done for exactly one cycle.
REQ-027 SHALL, when abort is high in RUN, return to IDLE next cycle with no step taken that cycle, no done pulse, and steps_left holding its remaining count.
REQ-028 SHALL give abort priority over a coincident final step.
REQ-029 SHALL ignore abort in IDLE.
REQ-030 SHALL, in IDLE, drive coil_signals to the table entry at the current index if IDLE_HOLD = 1, or 4'b0000 if IDLE_HOLD = 0; the index SHALL be retained in both cases.
REQ-031 SHALL, with IDLE_HOLD = 0, drive coil_signals to the current index pattern on the first RUN cycle, before the first step.
REQ-032 SHALL keep the index continuous across moves, so a direction reversal resumes from the current phase without skipping.

Reset
REQ-033 SHALL, while rst is high on a clock edge, set state = IDLE, index = 0, tick counter = 0, steps_left = 0, busy = 0, done = 0 and coil_signals = 4'b0000, regardless of IDLE_HOLD.
REQ-034 SHALL let reset asserted mid-move abort the move with no done pulse; after reset the next IDLE pattern follows REQ-030 from index 0.

Verification
REQ-035 SHALL cover half-mode forward: reset, start with mode = 10, dir = 0, steps = 3, period = 2 -> coils 1100, 0100, 0110 at cycles 3, 6, 9 after acceptance; done pulses with the third step; busy is high for 9 cycles.
REQ-036 SHALL cover full-mode reverse from index 0: steps = 2, period = 0, dir = 1 -> index 7 (1001), then 5 (0011), on consecutive clocks; done on the second.
REQ-037 SHALL cover abort: half mode, steps = 10, period = 4, abort asserted just after the 4th step -> busy drops next cycle, steps_left = 6, no done, coils hold the 4th pattern with IDLE_HOLD = 1.
REQ-038 SHALL cover zero-step start: start with steps = 0 -> single done pulse, busy stays 0, coils unchanged.
REQ-039 SHALL cover IDLE_HOLD = 0: after a completed move coils read 0000 in IDLE; the next start shows the retained pattern on the first RUN cycle.
REQ-040 SHALL cover mid-move reset: rst during RUN -> coils 0000, steps_left 0, busy 0 next cycle, no done.
